// File: rtl/hawk_axi_rd_arb.sv
// hawk_axi_rd_arb: two-requester (ATT / TOL) round-robin arbiter that turns
// table-entry IDs into single-beat 64-byte AXI4 reads, one read in flight.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   att_req_i/att_id_i           ATT requester: level request + entry ID
//   att_done_o/att_err_o         ATT one-cycle completion pulse + error flag
//   tol_req_i/tol_id_i           list (TOL) requester: level request + entry ID
//   tol_done_o/tol_err_o         TOL one-cycle completion pulse + error flag
//   rdata_o                      returned cache line, valid with a done pulse
//   ar*_o / arready_i            AXI4 read-address channel
//   rdata_i/rresp_i/rlast_i/
//   rvalid_i / rready_o          AXI4 read-data channel
module hawk_axi_rd_arb #(
  parameter logic [63:0] HAWK_ATT_START  = 64'h0000_0000_8000_0000,
  parameter logic [63:0] HAWK_LIST_START = 64'h0000_0000_8010_0000,
  parameter int unsigned ATT_ID_W        = 16,
  parameter int unsigned LST_ID_W        = 16,
  parameter int unsigned TMO_CYC         = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                att_req_i,
  input  logic [ATT_ID_W-1:0] att_id_i,
  output logic                att_done_o,
  output logic                att_err_o,
  input  logic                tol_req_i,
  input  logic [LST_ID_W-1:0] tol_id_i,
  output logic                tol_done_o,
  output logic                tol_err_o,
  output logic [511:0]        rdata_o,
  output logic [63:0]         araddr_o,
  output logic [7:0]          arlen_o,
  output logic [2:0]          arsize_o,
  output logic [1:0]          arburst_o,
  output logic [3:0]          arid_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  input  logic [511:0]        rdata_i,
  input  logic [1:0]          rresp_i,
  input  logic                rlast_i,
  input  logic                rvalid_i,
  output logic                rready_o
);

  localparam int unsigned WD_W = $clog2(TMO_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t         r_state;
  logic           r_gnt_tol;   // requester owning the current transaction
  logic           r_prio_tol;  // TOL wins the next tie
  logic           r_drain;     // a timed-out beat may still arrive
  logic [WD_W-1:0] r_wdog;
  logic [63:0]    r_araddr;
  logic [3:0]     r_arid;
  logic           r_arvalid;
  logic           r_rready;
  logic [511:0]   r_rdata;
  logic           r_att_done;
  logic           r_att_err;
  logic           r_tol_done;
  logic           r_tol_err;

  logic                w_gnt_any;
  logic                w_gnt_tol;
  logic                w_id_zero;
  logic [ATT_ID_W-1:0] w_att_idm1;
  logic [LST_ID_W-1:0] w_tol_idm1;
  logic [63:0]         w_att_addr;
  logic [63:0]         w_tol_addr;
  logic                w_rerr;
  logic                w_unused_rlast;

  // Single-beat reads: rlast carries no information here.
  assign w_unused_rlast = rlast_i;

  // Round-robin pick: a lone requester always wins, a tie goes to r_prio_tol.
  assign w_gnt_any = att_req_i | tol_req_i;
  assign w_gnt_tol = tol_req_i & (~att_req_i | r_prio_tol);
  assign w_id_zero = w_gnt_tol ? (tol_id_i == '0) : (att_id_i == '0);

  // Entry ID is 1-based; id-1 wraps in the ID width before widening.
  assign w_att_idm1 = att_id_i - ATT_ID_W'(1);
  assign w_tol_idm1 = tol_id_i - LST_ID_W'(1);
  assign w_att_addr = HAWK_ATT_START  + ((64'(w_att_idm1) >> 3) << 6);
  assign w_tol_addr = HAWK_LIST_START + ((64'(w_tol_idm1) >> 2) << 6);

  assign w_rerr = (rresp_i != 2'b00);

  // Main controller: arbitration, AXI handshakes, watchdog, completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_gnt_tol  <= 1'b0;
      r_prio_tol <= 1'b0;
      r_drain    <= 1'b0;
      r_wdog     <= '0;
      r_araddr   <= '0;
      r_arid     <= '0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_rdata    <= '0;
      r_att_done <= 1'b0;
      r_att_err  <= 1'b0;
      r_tol_done <= 1'b0;
      r_tol_err  <= 1'b0;
    end else begin
      // Completion outputs are single-cycle; rdata_o is zero outside RESP.
      r_att_done <= 1'b0;
      r_att_err  <= 1'b0;
      r_tol_done <= 1'b0;
      r_tol_err  <= 1'b0;
      r_rdata    <= '0;

      case (r_state)
        S_IDLE: begin
          if (r_drain && rvalid_i) begin
            r_rready <= 1'b0;
            r_drain  <= 1'b0;
          end
          if (w_gnt_any) begin
            r_gnt_tol  <= w_gnt_tol;
            r_prio_tol <= ~w_gnt_tol;
            r_rready   <= 1'b0;
            r_drain    <= 1'b0;
            r_arid     <= w_gnt_tol ? 4'd1 : 4'd0;
            if (w_id_zero) begin
              // ID 0 has no table entry: fail without touching the bus.
              r_att_done <= ~w_gnt_tol;
              r_att_err  <= ~w_gnt_tol;
              r_tol_done <= w_gnt_tol;
              r_tol_err  <= w_gnt_tol;
              r_state    <= S_RESP;
            end else begin
              r_araddr  <= w_gnt_tol ? w_tol_addr : w_att_addr;
              r_arvalid <= 1'b1;
              r_state   <= S_ADDR;
            end
          end
        end

        S_ADDR: begin
          if (arready_i) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_wdog    <= '0;
            r_state   <= S_DATA;
          end
        end

        S_DATA: begin
          if (rvalid_i) begin
            r_rready   <= 1'b0;
            r_rdata    <= rdata_i;
            r_att_done <= ~r_gnt_tol;
            r_att_err  <= ~r_gnt_tol & w_rerr;
            r_tol_done <= r_gnt_tol;
            r_tol_err  <= r_gnt_tol & w_rerr;
            r_state    <= S_RESP;
          end else if (r_wdog == WD_W'(TMO_CYC - 1)) begin
            // Give up; keep rready high so a late beat is swallowed later.
            r_drain    <= 1'b1;
            r_att_done <= ~r_gnt_tol;
            r_att_err  <= ~r_gnt_tol;
            r_tol_done <= r_gnt_tol;
            r_tol_err  <= r_gnt_tol;
            r_state    <= S_RESP;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
        end

        S_RESP: begin
          if (r_drain && rvalid_i) begin
            r_rready <= 1'b0;
            r_drain  <= 1'b0;
          end
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign att_done_o = r_att_done;
  assign att_err_o  = r_att_err;
  assign tol_done_o = r_tol_done;
  assign tol_err_o  = r_tol_err;
  assign rdata_o    = r_rdata;
  assign araddr_o   = r_araddr;
  assign arlen_o    = 8'd0;
  assign arsize_o   = 3'd6;
  assign arburst_o  = 2'b01;
  assign arid_o     = r_arid;
  assign arvalid_o  = r_arvalid;
  assign rready_o   = r_rready;

endmodule

// File: tb/tb_hawk_axi_rd_arb.sv
// Self-checking bench for hawk_axi_rd_arb: requester drivers and an AXI slave
// produce stimulus; a negedge monitor predicts grants from request levels and
// checks AR beats and completion pulses against queued expectations.
module tb_hawk_axi_rd_arb;

  localparam logic [63:0] ATT_BASE  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] LIST_BASE = 64'h0000_0000_8010_0000;
  localparam int          TMO       = 1024;

  typedef struct { logic tol; logic idz; }           gnt_t;
  typedef struct { logic [63:0] addr; logic [3:0] id; } ar_t;
  typedef struct { logic [511:0] data; logic err; }  beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i;
  logic          att_req_i, tol_req_i;
  logic [15:0]   att_id_i, tol_id_i;
  logic          att_done_o, att_err_o, tol_done_o, tol_err_o;
  logic [511:0]  rdata_o;
  logic [63:0]   araddr_o;
  logic [7:0]    arlen_o;
  logic [2:0]    arsize_o;
  logic [1:0]    arburst_o;
  logic [3:0]    arid_o;
  logic          arvalid_o, rready_o;

  // Slave-model and manual AXI drives, muxed onto the DUT inputs.
  logic          slave_en;
  logic          s_arready, s_rvalid, m_arready, m_rvalid;
  logic [511:0]  s_rdata, m_rdata;
  logic [1:0]    s_rresp;
  logic          arready_w, rvalid_w;
  logic [511:0]  rdata_w;
  logic [1:0]    rresp_w;
  assign arready_w = slave_en ? s_arready : m_arready;
  assign rvalid_w  = slave_en ? s_rvalid  : m_rvalid;
  assign rdata_w   = slave_en ? s_rdata   : m_rdata;
  assign rresp_w   = slave_en ? s_rresp   : 2'b00;

  hawk_axi_rd_arb dut (
    .clk_i(clk), .rst_i(rst_i),
    .att_req_i(att_req_i), .att_id_i(att_id_i),
    .att_done_o(att_done_o), .att_err_o(att_err_o),
    .tol_req_i(tol_req_i), .tol_id_i(tol_id_i),
    .tol_done_o(tol_done_o), .tol_err_o(tol_err_o),
    .rdata_o(rdata_o), .araddr_o(araddr_o), .arlen_o(arlen_o),
    .arsize_o(arsize_o), .arburst_o(arburst_o), .arid_o(arid_o),
    .arvalid_o(arvalid_o), .arready_i(arready_w),
    .rdata_i(rdata_w), .rresp_i(rresp_w), .rlast_i(rvalid_w),
    .rvalid_i(rvalid_w), .rready_o(rready_o)
  );

  int n_chk = 0, n_fail = 0, cyc = 0, ar_cnt = 0, n_done = 0;
  bit rst_q;
  gnt_t  done_q[$];
  ar_t   ar_q[$];
  beat_t beat_q[$];
  logic  order_q[$];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_i;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk512(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Line address of an entry: 8 ATT entries or 4 list entries per 64-byte line.
  function automatic logic [63:0] exp_addr(input logic tol, input logic [15:0] id);
    logic [15:0] idm1;
    idm1 = id - 16'd1;
    if (tol) return LIST_BASE + 64'(idm1 / 4) * 64;
    return ATT_BASE + 64'(idm1 / 8) * 64;
  endfunction

  // ---------------- reference model + monitor ----------------
  bit          m_busy = 0;
  bit          m_last_tol = 1;  // ATT wins the first tie
  bit          m_gtol;
  logic [15:0] m_id;
  bit          p_arvalid = 0, p_hs = 0;
  logic [63:0] p_addr;
  logic [3:0]  p_id;
  gnt_t        g;
  beat_t       b;
  ar_t         a;

  always @(negedge clk) begin
    if (rst_q) begin
      chk("rst_arvalid", 64'(arvalid_o), 0);
      chk("rst_rready",  64'(rready_o), 0);
      chk("rst_done",    64'({att_done_o, tol_done_o}), 0);
      chk("rst_err",     64'({att_err_o, tol_err_o}), 0);
      chk("rst_araddr",  araddr_o, 0);
      chk512("rst_rdata", rdata_o, '0);
    end
    if (!rst_i && !m_busy && (att_req_i || tol_req_i)) begin
      m_gtol     = (att_req_i && tol_req_i) ? !m_last_tol : tol_req_i;
      m_id       = m_gtol ? tol_id_i : att_id_i;
      m_last_tol = m_gtol;
      m_busy     = 1;
      if (m_id == 16'd0) done_q.push_back(gnt_t'{m_gtol, 1'b1});
      else begin
        ar_q.push_back(ar_t'{exp_addr(m_gtol, m_id), m_gtol ? 4'd1 : 4'd0});
        done_q.push_back(gnt_t'{m_gtol, 1'b0});
      end
    end
    if (arvalid_o === 1'b1) ar_cnt++;
    if (p_arvalid && !p_hs && !rst_q) begin
      chk("ar_hold_valid", 64'(arvalid_o), 1);
      chk("ar_hold_addr", araddr_o, p_addr);
      chk("ar_hold_id", 64'(arid_o), 64'(p_id));
    end
    p_arvalid = (arvalid_o === 1'b1);
    p_hs      = (arvalid_o === 1'b1) && (arready_w === 1'b1);
    p_addr    = araddr_o;
    p_id      = arid_o;
    if (p_hs) begin
      chk("ar_expected", 64'(ar_q.size() > 0), 1);
      chk("arlen", 64'(arlen_o), 0);
      chk("arsize", 64'(arsize_o), 6);
      chk("arburst", 64'(arburst_o), 1);
      if (ar_q.size() > 0) begin
        a = ar_q.pop_front();
        chk("araddr", araddr_o, a.addr);
        chk("arid", 64'(arid_o), 64'(a.id));
      end
    end
    if (att_done_o === 1'b1 || tol_done_o === 1'b1) begin
      n_done++;
      chk("done_one_hot", 64'(att_done_o && tol_done_o), 0);
      chk("done_expected", 64'(done_q.size() > 0), 1);
      if (done_q.size() > 0) begin
        g = done_q.pop_front();
        order_q.push_back(g.tol);
        chk("done_requester", 64'(tol_done_o), 64'(g.tol));
        if (g.idz) begin
          b.data = '0;
          b.err  = 1'b1;
        end else begin
          chk("beat_available", 64'(beat_q.size() > 0), 1);
          if (beat_q.size() > 0) b = beat_q.pop_front();
        end
        chk("done_err", 64'(g.tol ? tol_err_o : att_err_o), 64'(b.err));
        chk512("done_rdata", rdata_o, b.data);
      end
      m_busy = 0;
    end
    if (rst_i) begin
      m_busy = 0;
      m_last_tol = 1;
      done_q.delete();
      ar_q.delete();
      beat_q.delete();
    end
  end

  // ---------------- AXI slave model ----------------
  bit       slave_rand;
  int       cfg_stall, cfg_delay;
  logic [1:0] cfg_resp;
  int       s_phase, s_stall, s_dly;

  function automatic int pick_stall();
    return slave_rand ? int'($urandom_range(0, 3)) : cfg_stall;
  endfunction
  function automatic int pick_delay();
    return slave_rand ? int'($urandom_range(0, 3)) : cfg_delay;
  endfunction
  function automatic logic [1:0] pick_resp();
    if (!slave_rand) return cfg_resp;
    if ($urandom_range(0, 4) == 0) return 2'($urandom_range(1, 3));
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rst_q || !slave_en) begin
      s_arready = 0; s_rvalid = 0; s_phase = 0; s_stall = pick_stall();
    end else begin
      case (s_phase)
        0: begin
          s_rvalid = 0;
          if (arvalid_o === 1'b1) begin
            if (s_stall == 0) begin
              s_arready = 1; s_phase = 1; s_dly = pick_delay();
            end else begin
              s_arready = 0; s_stall--;
            end
          end else s_arready = 0;
        end
        1: begin
          s_arready = 0;
          if (s_dly == 0) begin
            s_rdata  = rand512();
            s_rresp  = pick_resp();
            s_rvalid = 1;
            beat_q.push_back(beat_t'{s_rdata, s_rresp != 2'b00});
            s_phase  = 2;
          end else s_dly--;
        end
        default: begin
          s_rvalid = 0; s_phase = 0; s_stall = pick_stall();
        end
      endcase
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_req(input bit tol, input bit v, input logic [15:0] id);
    if (tol) begin tol_req_i = v; tol_id_i = id; end
    else begin att_req_i = v; att_id_i = id; end
  endtask

  task automatic wait_done(input bit tol, input int budget, output int dcyc);
    bit got = 0;
    dcyc = -1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if ((tol ? tol_done_o : att_done_o) === 1'b1) begin got = 1; dcyc = cyc; end
    end
    chk(tol ? "tol_done_seen" : "att_done_seen", 64'(got), 1);
  endtask

  task automatic do_single(input bit tol, input logic [15:0] id, input int exp_lat);
    int k, d;
    @(posedge clk); #1;
    drive_req(tol, 1, id);
    k = cyc;
    wait_done(tol, 3000, d);
    if (exp_lat >= 0) chk("latency", 64'(d - k), 64'(exp_lat));
    @(posedge clk); #1;
    drive_req(tol, 0, 16'd0);
  endtask

  function automatic logic [15:0] pick_id();
    int r = $urandom_range(0, 9);
    if (r == 0) return 16'd0;
    if (r < 5) return 16'($urandom_range(1, 40));
    return 16'($urandom_range(1, 65535));
  endfunction

  task automatic requester(input bit tol, input int n, input int maxgap);
    int d, gap;
    @(posedge clk); #1;
    drive_req(tol, 1, pick_id());
    for (int i = 0; i < n; i++) begin
      wait_done(tol, 3000, d);
      @(posedge clk); #1;
      if (d < 0 || i == n - 1) begin
        drive_req(tol, 0, 16'd0);
        break;
      end
      gap = $urandom_range(0, maxgap);
      if (gap == 0) drive_req(tol, 1, pick_id());
      else begin
        drive_req(tol, 0, 16'd0);
        repeat (gap) @(posedge clk);
        #1;
        drive_req(tol, 1, pick_id());
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_i = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 0;
  endtask

  int k, d, h, a0, n0;
  logic exp_order[4];

  initial begin
    rst_i = 1; att_req_i = 0; tol_req_i = 0; att_id_i = 0; tol_id_i = 0;
    slave_en = 1; slave_rand = 0; cfg_stall = 0; cfg_delay = 0; cfg_resp = 2'b00;
    m_arready = 0; m_rvalid = 0; m_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 0;

    // minimum-latency reads and address mapping
    do_single(0, 16'd9, 3);
    do_single(1, 16'd5, 3);
    do_single(1, 16'd4, 3);

    // ID 0: no bus traffic, error completion one cycle after grant
    a0 = ar_cnt;
    do_single(0, 16'd0, 1);
    chk("id0_no_arvalid", 64'(ar_cnt - a0), 0);

    // slave error response; a TOL request withdrawn before grant is dropped
    cfg_resp = 2'b10; cfg_delay = 5;
    @(posedge clk); #1;
    drive_req(0, 1, 16'd20);
    @(posedge clk); #1;
    drive_req(1, 1, 16'd7);
    @(posedge clk); #1;
    drive_req(1, 0, 16'd0);
    wait_done(0, 100, d);
    @(posedge clk); #1;
    drive_req(0, 0, 16'd0);
    cfg_resp = 2'b00; cfg_delay = 1;

    // AR held off for 10 cycles
    cfg_stall = 10;
    do_single(0, 16'd100, -1);
    cfg_stall = 0;

    // R-channel watchdog, then a late beat drained silently
    slave_en = 0;
    @(posedge clk); #1;
    drive_req(0, 1, 16'd3);
    h = -1;
    for (int i = 0; i < 20 && h < 0; i++) begin
      @(posedge clk); #1;
      if (arvalid_o === 1'b1) begin m_arready = 1; h = cyc; end
    end
    chk("tmo_arvalid_seen", 64'(h >= 0), 1);
    @(posedge clk); #1;
    m_arready = 0;
    beat_q.push_back(beat_t'{512'd0, 1'b1});
    wait_done(0, TMO + 50, d);
    chk("tmo_cycles", 64'(d - h), 64'(1 + TMO));
    @(posedge clk); #1;
    drive_req(0, 0, 16'd0);
    @(negedge clk);
    chk("drain_rready_idle", 64'(rready_o), 1);
    n0 = n_done;
    @(posedge clk); #1;
    m_rvalid = 1; m_rdata = rand512();
    @(posedge clk); #1;
    m_rvalid = 0;
    @(negedge clk);
    chk("drain_rready_off", 64'(rready_o), 0);
    repeat (5) @(negedge clk);
    chk("drain_no_done", 64'(n_done - n0), 0);
    slave_en = 1;

    // reset while waiting for the R beat
    cfg_delay = 6;
    @(posedge clk); #1;
    drive_req(0, 1, 16'd2);
    h = -1;
    for (int i = 0; i < 20 && h < 0; i++) begin
      @(negedge clk);
      if (arvalid_o === 1'b1 && arready_w === 1'b1) h = cyc;
    end
    chk("rstdata_hs_seen", 64'(h >= 0), 1);
    n0 = n_done;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_i = 1;
    drive_req(0, 0, 16'd0);
    @(posedge clk); #1;
    rst_i = 0;
    repeat (10) @(negedge clk);
    chk("rstdata_no_done", 64'(n_done - n0), 0);
    cfg_delay = 0;

    // both requesters held high: strict alternation starting with ATT
    order_q.delete();
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
    fork
      requester(0, 2, 0);
      requester(1, 2, 0);
    join
    chk("order_len", 64'(order_q.size()), 4);
    if (order_q.size() >= 4)
      for (int i = 0; i < 4; i++) chk("grant_order", 64'(order_q[i]), 64'(exp_order[i]));

    // randomized traffic
    slave_rand = 1;
    fork
      requester(0, 15, 3);
      requester(1, 15, 3);
    join
    repeat (10) @(negedge clk);
    chk("left_done_q", 64'(done_q.size()), 0);
    chk("left_ar_q", 64'(ar_q.size()), 0);
    chk("left_beat_q", 64'(beat_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule
